// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel on/off waveform generator with glitch-free runtime reconfiguration
// Ports: CLK100MHZ clock, CPU_RESETN async active-low reset, en per-channel run enable,
//   cfg_valid/cfg_ready/cfg_ch/cfg_on/cfg_off/cfg_num config write port,
//   out registered waveforms, done one-cycle run-complete strobes.
module pwm_bank #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 28,
  parameter int NUM_W    = 16,
  parameter int CH_W     = 4
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_on,
  input  logic [CNT_W-1:0]    cfg_off,
  input  logic [NUM_W-1:0]    cfg_num,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] done
);
  localparam int PW = 1 << CH_W;
  localparam logic [1:0] IDLE = 2'd0, ON = 2'd1, OFF = 2'd2, HOLD = 2'd3;
  localparam logic [CNT_W-1:0] ONE_C = 1;
  localparam logic [NUM_W-1:0] ONE_N = 1;
  logic [CHANNELS-1:0] pend;
  logic [PW-1:0] pend_ext;
  // zero-extended so out-of-range channel indices read as "not pending" -> ready
  assign pend_ext = PW'(pend);
  assign cfg_ready = ~pend_ext[cfg_ch];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0] st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, on_q, on_d, off_q, off_d, pon_q, pon_d, poff_q, poff_d, eon, eoff;
    logic [NUM_W-1:0] pcnt_q, pcnt_d, num_q, num_d, pnum_q, pnum_d;
    logic pend_q, pend_d, out_q, acc, last, fin, start, load;
    assign acc = cfg_valid & cfg_ready & (cfg_ch == CH_W'(c));
    // last cycle of a period: end of OFF, or end of ON when there is no OFF phase
    assign last = (st_q == ON && cnt_q == on_q - ONE_C && off_q == '0) ||
                  (st_q == OFF && cnt_q == off_q - ONE_C);
    assign fin = last && num_q != '0 && pcnt_q + ONE_N == num_q;
    assign done[c] = fin & en[c];
    assign out[c] = out_q;
    assign pend[c] = pend_q;
    always_comb begin
      st_d = st_q;
      cnt_d = (st_q == ON || st_q == OFF) ? cnt_q + ONE_C : cnt_q;
      pcnt_d = pcnt_q;
      on_d = on_q;
      off_d = off_q;
      num_d = num_q;
      pon_d = acc ? cfg_on : pon_q;
      poff_d = acc ? cfg_off : poff_q;
      pnum_d = acc ? cfg_num : pnum_q;
      pend_d = pend_q | acc;
      start = 1'b0;
      load = 1'b0;
      if (!en[c]) begin
        st_d = IDLE;
        cnt_d = '0;
        pcnt_d = '0;
      end else if (st_q == IDLE) begin
        start = 1'b1;
        load = pend_q;
        pcnt_d = '0;
      end else if (last) begin
        pcnt_d = pcnt_q + ONE_N;
        if (fin) st_d = HOLD;
        else begin
          start = 1'b1;
          load = pend_q;
          if (pend_q) pcnt_d = '0;
        end
      end else if (st_q == ON && cnt_q == on_q - ONE_C) begin
        st_d = OFF;
        cnt_d = '0;
      end
      if (load) begin
        on_d = pon_q;
        off_d = poff_q;
        num_d = pnum_q;
        pend_d = 1'b0;
      end
      // a period starts from the values that will be active after any load
      eon = load ? pon_q : on_q;
      eoff = load ? poff_q : off_q;
      if (start) begin
        st_d = eon != '0 ? ON : eoff != '0 ? OFF : IDLE;
        cnt_d = '0;
      end
    end
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        st_q <= IDLE;
        cnt_q <= '0;
        pcnt_q <= '0;
        on_q <= '0;
        off_q <= '0;
        num_q <= '0;
        pon_q <= '0;
        poff_q <= '0;
        pnum_q <= '0;
        pend_q <= 1'b0;
        out_q <= 1'b0;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
        pcnt_q <= pcnt_d;
        on_q <= on_d;
        off_q <= off_d;
        num_q <= num_d;
        pon_q <= pon_d;
        poff_q <= poff_d;
        pnum_q <= pnum_d;
        pend_q <= pend_d;
        out_q <= st_d == ON;
      end
    end
  end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: randomized and directed checks of pwm_bank against a period-position reference model
module tb_pwm_bank;
  localparam int N = 4;
  localparam int IDLE = 0, RUN = 1, HOLD = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] en = '0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [3:0] cfg_ch = '0;
  logic [27:0] cfg_on = '0;
  logic [27:0] cfg_off = '0;
  logic [15:0] cfg_num = '0;
  logic [N-1:0] out, done;
  int tests = 0;
  int fails = 0;
  int m_on[N], m_off[N], m_num[N], p_on[N], p_off[N], p_num[N], m_mode[N], m_pos[N], m_cnt[N];
  bit m_pend[N];
  logic [N-1:0] exp_out, exp_done, obs_out, obs_done;
  logic exp_ready, obs_ready;

  pwm_bank #(.CHANNELS(N), .CNT_W(28), .NUM_W(16), .CH_W(4)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_num(cfg_num), .out(out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_on[i] = 0; m_off[i] = 0; m_num[i] = 0;
      p_on[i] = 0; p_off[i] = 0; p_num[i] = 0;
      m_pend[i] = 0; m_mode[i] = IDLE; m_pos[i] = 0; m_cnt[i] = 0;
    end
    exp_out = '0;
  endtask

  task automatic take(input int i);
    m_on[i] = p_on[i]; m_off[i] = p_off[i]; m_num[i] = p_num[i]; m_pend[i] = 0;
  endtask

  // One clock: sample combinational outputs mid-cycle, then advance model past the edge.
  task automatic tick();
    logic [N-1:0] en_s;
    bit acc;
    int ach, a_on, a_off, a_num;
    @(negedge clk);
    en_s = en;
    for (int i = 0; i < N; i++)
      exp_done[i] = m_mode[i] == RUN && m_pos[i] == m_on[i] + m_off[i] - 1 &&
                    m_num[i] != 0 && m_cnt[i] + 1 == m_num[i] && en_s[i];
    exp_ready = (cfg_ch >= 4'(N)) ? 1'b1 : !m_pend[cfg_ch[1:0]];
    obs_done = done;
    obs_ready = cfg_ready;
    acc = cfg_valid && exp_ready && cfg_ch < 4'(N);
    ach = int'(cfg_ch[1:0]); a_on = int'(cfg_on); a_off = int'(cfg_off); a_num = int'(cfg_num);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!en_s[i]) begin
        m_mode[i] = IDLE; m_pos[i] = 0; m_cnt[i] = 0;
      end else if (m_mode[i] == IDLE) begin
        if (m_pend[i]) take(i);
        m_cnt[i] = 0; m_pos[i] = 0;
        if (m_on[i] + m_off[i] > 0) m_mode[i] = RUN;
      end else if (m_mode[i] == RUN) begin
        if (m_pos[i] == m_on[i] + m_off[i] - 1) begin
          m_cnt[i]++; m_pos[i] = 0;
          if (m_num[i] != 0 && m_cnt[i] == m_num[i]) m_mode[i] = HOLD;
          else begin
            if (m_pend[i]) begin take(i); m_cnt[i] = 0; end
            if (m_on[i] + m_off[i] == 0) m_mode[i] = IDLE;
          end
        end else m_pos[i]++;
      end
    end
    if (acc) begin
      p_on[ach] = a_on; p_off[ach] = a_off; p_num[ach] = a_num; m_pend[ach] = 1;
    end
    for (int i = 0; i < N; i++) exp_out[i] = m_mode[i] == RUN && m_pos[i] < m_on[i];
    obs_out = out;
  endtask

  task automatic cfg(input int ch, input int on, input int off, input int num);
    cfg_valid = 1'b1; cfg_ch = 4'(ch); cfg_on = 28'(on); cfg_off = 28'(off); cfg_num = 16'(num);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out !== '0 || done !== '0 || cfg_ready !== 1'b1) begin
      fails++; $display("FAIL reset out=%b done=%b ready=%b exp 0000/0000/1", out, done, cfg_ready);
    end
    rst_n = 1'b1;
    model_reset();
    en = '1;
    repeat (4) begin
      tick();
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL reset_idle got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
    end
    en = '0;
    tick();
  endtask

  task automatic test_free_run();
    logic [9:0] pat = '0;
    int dn = 0;
    cfg(0, 3, 2, 0);
    en[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k < 10) pat = {pat[8:0], obs_out[0]};
      dn += int'(obs_done[0]);
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL free_run got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
    end
    tests++;
    if (pat !== 10'b1110011100) begin fails++; $display("FAIL free_run_pattern got %b exp 1110011100", pat); end
    tests++;
    if (dn != 0) begin fails++; $display("FAIL free_run_done got %0d pulses exp 0", dn); end
  endtask

  task automatic test_counted();
    cfg(1, 1, 1, 4);
    for (int r = 0; r < 2; r++) begin
      int highs = 0;
      int dn = 0;
      en[1] = 1'b1;
      repeat (14) begin
        tick();
        highs += int'(obs_out[1]);
        dn += int'(obs_done[1]);
        tests++;
        if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
          fails++; $display("FAIL counted got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
        end
      end
      tests++;
      if (highs != 4 || dn != 1 || obs_out[1] !== 1'b0) begin
        fails++; $display("FAIL counted_run%0d highs=%0d done=%0d out=%b exp 4/1/0", r, highs, dn, obs_out[1]);
      end
      en[1] = 1'b0;
      tick();
    end
    en[1] = 1'b1;
  endtask

  task automatic test_reconfig();
    logic prev = obs_out[0];
    logic [9:0] pat = '0;
    bit found = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL reconfig_wait got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
      if (obs_out[0] && !prev) begin found = 1; break; end
      prev = obs_out[0];
    end
    tests++;
    if (!found) begin fails++; $display("FAIL reconfig_on_edge got none exp rising out[0] within 20 cycles"); end
    cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_on = 28'd1; cfg_off = 28'd4; cfg_num = 16'd0;
    tick();
    pat = {pat[8:0], obs_out[0]};
    tests++;
    if (obs_ready !== 1'b1) begin fails++; $display("FAIL reconfig_first_ready got %b exp 1", obs_ready); end
    cfg_on = 28'd7; cfg_off = 28'd7;
    tick();
    pat = {pat[8:0], obs_out[0]};
    tests++;
    if (obs_ready !== 1'b0) begin fails++; $display("FAIL reconfig_second_ready got %b exp 0", obs_ready); end
    cfg_valid = 1'b0;
    repeat (8) begin
      tick();
      pat = {pat[8:0], obs_out[0]};
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL reconfig got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
    end
    tests++;
    if (pat !== 10'b1100100001) begin fails++; $display("FAIL reconfig_pattern got %b exp 1100100001", pat); end
  endtask

  task automatic test_edge_lengths();
    int highs = 0;
    int dn = 0;
    cfg(2, 0, 5, 2);
    en[2] = 1'b1;
    repeat (14) begin
      tick();
      highs += int'(obs_out[2]);
      dn += int'(obs_done[2]);
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL on_zero got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
    end
    tests++;
    if (highs != 0 || dn != 1) begin fails++; $display("FAIL on_zero_counts highs=%0d done=%0d exp 0/1", highs, dn); end
    cfg(2, 5, 0, 0);
    en[2] = 1'b0;
    tick();
    en[2] = 1'b1;
    tick();
    highs = 0;
    repeat (12) begin
      tick();
      highs += int'(obs_out[2]);
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL off_zero got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
    end
    tests++;
    if (highs != 12) begin fails++; $display("FAIL off_zero_constant highs=%0d exp 12", highs); end
    en[3] = 1'b1;
    highs = 0;
    repeat (6) begin
      tick();
      highs += int'(obs_out[3]);
    end
    tests++;
    if (highs != 0) begin fails++; $display("FAIL both_zero_idle highs=%0d exp 0", highs); end
    cfg(3, 2, 2, 0);
    tick();
    tests++;
    if (obs_out[3] !== 1'b1) begin fails++; $display("FAIL idle_accept_start got %b exp 1", obs_out[3]); end
    en[3:2] = 2'b00;
    tick();
  endtask

  task automatic test_disable_reset();
    logic prev = obs_out[0];
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      found = obs_out[0] && !prev;
      prev = obs_out[0];
    end
    en[0] = 1'b0;
    tick();
    tests++;
    if (!found || obs_out[0] !== 1'b0 || obs_done[0] !== 1'b0) begin
      fails++; $display("FAIL disable_mid_on found=%0d out=%b done=%b exp 1/0/0", found, obs_out[0], obs_done[0]);
    end
    en[0] = 1'b1;
    cfg(1, 3, 3, 0);
    tests++;
    if (obs_ready !== 1'b1) begin fails++; $display("FAIL pend_write_ready got %b exp 1", obs_ready); end
    prev = obs_out[0];
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      found = obs_out[0] && !prev;
      prev = obs_out[0];
    end
    tests++;
    if (!found || obs_out[0] !== 1'b1) begin fails++; $display("FAIL pre_reset_high got %b exp 1", obs_out[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out !== '0 || cfg_ready !== 1'b1) begin
      fails++; $display("FAIL async_reset out=%b ready=%b exp 0000/1", out, cfg_ready);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL post_reset got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
    end
    tests++;
    if (obs_out[1] !== 1'b0) begin fails++; $display("FAIL pending_lost got %b exp 0", obs_out[1]); end
    en = '0;
    tick();
  endtask

  task automatic test_oob_multi();
    int h2 = 0;
    int h3 = 0;
    cfg(5, 3, 3, 0);
    tests++;
    if (obs_ready !== 1'b1) begin fails++; $display("FAIL oob_ready got %b exp 1", obs_ready); end
    cfg(2, 2, 3, 0);
    cfg(3, 1, 1, 0);
    en[3:2] = 2'b11;
    repeat (25) begin
      tick();
      h2 += int'(obs_out[2]);
      h3 += int'(obs_out[3]);
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL multi got %b/%b/%b exp %b/%b/%b", obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
    end
    tests++;
    if (h2 != 10 || h3 != 13 || obs_out[1:0] !== 2'b00) begin
      fails++; $display("FAIL multi_counts h2=%0d h3=%0d low=%b exp 10/13/00", h2, h3, obs_out[1:0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        int b = int'($urandom_range(0, 3));
        en[b] = ~en[b];
      end
      cfg_valid = $urandom_range(0, 3) == 0;
      cfg_ch = 4'($urandom_range(0, 5));
      cfg_on = 28'($urandom_range(0, 4));
      cfg_off = 28'($urandom_range(0, 4));
      cfg_num = 16'($urandom_range(0, 3));
      tick();
      tests++;
      if ({obs_out, obs_done, obs_ready} !== {exp_out, exp_done, exp_ready}) begin
        fails++; $display("FAIL random k=%0d got %b/%b/%b exp %b/%b/%b", k, obs_out, obs_done, obs_ready, exp_out, exp_done, exp_ready);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_counted();
    test_reconfig();
    test_edge_lengths();
    test_disable_reset();
    test_oob_multi();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
